// File: rtl/sparc_exu_div_pkg.sv
// Shared definitions for the EXU divide/multiply Y register control.
// Select encodings are one-hot so each bit maps straight to a mux4ds leg.
package sparc_exu_div_pkg;

  localparam int NTHR_DEF = 4;

  typedef enum logic [3:0] {
    SEL_L  = 4'b0001,
    SEL_SH = 4'b0010,
    SEL_G  = 4'b0100,
    SEL_W  = 4'b1000
  } yreg_sel_e;

endpackage

// File: rtl/sparc_exu_div_yreg_ctl_thr.sv
// Per-thread Y select priority and busy scoreboard bit.
// Exactly one select leg is high at all times.
module sparc_exu_div_yreg_ctl_thr
  import sparc_exu_div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic pend,
  input  logic mul_req,
  input  logic sh_req,
  output logic wen_w,
  output logic wen_g,
  output logic wen_l,
  output logic shift,
  output logic busy,
  output logic conflict
);

  yreg_sel_e sel;

  // Priority pick: W2 write, then multiplier, then MULScc shift, else hold.
  always_comb begin
    sel = SEL_L;
    priority case (1'b1)
      pend:    sel = SEL_W;
      mul_req: sel = SEL_G;
      sh_req:  sel = SEL_SH;
      default: sel = SEL_L;
    endcase
  end

  assign wen_w = sel[3];
  assign wen_g = sel[2];
  assign shift = sel[1];
  assign wen_l = sel[0];

  assign conflict = (pend & mul_req) | (pend & sh_req) | (mul_req & sh_req);

  // Busy from commit until the W2 write; a new commit wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       busy <= 1'b0;
    else if (commit) busy <= 1'b1;
    else if (wen_w)  busy <= 1'b0;
  end

  a_sel_1h: assert property (@(posedge clk) $onehot(sel));

endmodule

// File: rtl/sparc_exu_div_yreg_ctl.sv
// Y register write/shift sequencer: WRY delay pipe, per-thread selects,
// RDY stall and sticky same-thread conflict flag.
module sparc_exu_div_yreg_ctl
  import sparc_exu_div_pkg::*;
#(
  parameter int NTHR = NTHR_DEF,
  parameter int YDLY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wry_vld_w,
  input  logic [NTHR-1:0] wry_thr_w,
  input  logic            flush_w,
  input  logic            mul_wen_g,
  input  logic [NTHR-1:0] mul_thr_g,
  input  logic            muls_vld_g,
  input  logic [NTHR-1:0] muls_thr_g,
  input  logic            muls_rs1_0_g,
  input  logic            rdy_vld_e,
  input  logic [NTHR-1:0] rdy_thr_e,
  output logic [NTHR-1:0] ecl_div_yreg_wen_w,
  output logic [NTHR-1:0] ecl_div_yreg_wen_g,
  output logic [NTHR-1:0] ecl_div_yreg_wen_l,
  output logic [NTHR-1:0] ecl_div_yreg_shift_g,
  output logic            ecl_div_yreg_data_31_g,
  output logic [NTHR-1:0] yreg_busy,
  output logic            yreg_rdy_stall_e,
  output logic            yreg_conflict_err
);

  logic [NTHR-1:0] wry_pend_now;
  logic [NTHR-1:0] pipe [YDLY];
  logic [NTHR-1:0] pend_w2;
  logic [NTHR-1:0] mul_req;
  logic [NTHR-1:0] sh_req;
  logic [NTHR-1:0] conflict;

  assign wry_pend_now = (wry_vld_w & ~flush_w) ? wry_thr_w : '0;

  // WRY commit delay pipe; a flushed WRY never enters it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < YDLY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= wry_pend_now;
      for (int i = 1; i < YDLY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pend_w2 = pipe[YDLY-1];

  // G-stage requests are masked in reset so every thread selects hold.
  assign mul_req = (mul_wen_g & ~reset) ? mul_thr_g : '0;
  assign sh_req  = (muls_vld_g & ~reset) ? muls_thr_g : '0;

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    sparc_exu_div_yreg_ctl_thr u_thr (
      .clk      (clk),
      .reset    (reset),
      .commit   (wry_pend_now[t]),
      .pend     (pend_w2[t]),
      .mul_req  (mul_req[t]),
      .sh_req   (sh_req[t]),
      .wen_w    (ecl_div_yreg_wen_w[t]),
      .wen_g    (ecl_div_yreg_wen_g[t]),
      .wen_l    (ecl_div_yreg_wen_l[t]),
      .shift    (ecl_div_yreg_shift_g[t]),
      .busy     (yreg_busy[t]),
      .conflict (conflict[t])
    );
  end

  assign ecl_div_yreg_data_31_g = (|ecl_div_yreg_shift_g) & muls_rs1_0_g;

  assign yreg_rdy_stall_e = rdy_vld_e &
                            (|(rdy_thr_e & (yreg_busy | wry_pend_now)));

  // Sticky flag for any thread seeing two updates in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          yreg_conflict_err <= 1'b0;
    else if (|conflict) yreg_conflict_err <= 1'b1;
  end

  a_wry_1h: assert property (@(posedge clk) disable iff (reset)
    wry_vld_w |-> $onehot(wry_thr_w));
  a_mul_1h: assert property (@(posedge clk) disable iff (reset)
    mul_wen_g |-> $onehot(mul_thr_g));
  a_muls_1h: assert property (@(posedge clk) disable iff (reset)
    muls_vld_g |-> $onehot(muls_thr_g));
  a_rdy_1h: assert property (@(posedge clk) disable iff (reset)
    rdy_vld_e |-> $onehot(rdy_thr_e));

endmodule
